// File: rtl/gpio_wiggle_gen.sv
// gpio_wiggle_gen: multi-channel GPIO pattern generator.
// Each of CHANNELS banks owns a WIDTH-bit pattern register that drives its
// slice of gpio directly. A free-running divider per bank produces a tick
// every div+1 cycles while enabled, and each tick applies the bank's mode
// update (hold, toggle, walking-one rotate, binary count).
// Optional feature macro: GPIO_WIGGLE_BURST_EN adds a per-channel burst
// length that auto-disables the channel after a fixed number of ticks and
// pulses done on the last one.
module gpio_wiggle_gen #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int DIV_W    = 24
) (
  input  logic                      osc,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_ch,
  input  logic [2:0]                cfg_sel,
  input  logic [31:0]               cfg_wdata,
  output logic [CHANNELS*WIDTH-1:0] gpio,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       done
);

  localparam logic [2:0] SEL_PATTERN = 3'd0;
  localparam logic [2:0] SEL_DIV     = 3'd1;
  localparam logic [2:0] SEL_MODE    = 3'd2;
  localparam logic [2:0] SEL_CTRL    = 3'd3;
`ifdef GPIO_WIGGLE_BURST_EN
  localparam logic [2:0] SEL_BURST   = 3'd4;
`endif

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  // Write data is truncated per register; the upper bits are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] pat_upd;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             en_q;
    logic             tick_q;
    logic             wr_ch;
    logic             tick_now;
`ifdef GPIO_WIGGLE_BURST_EN
    logic [15:0]      burst_q;
    logic [15:0]      bleft_q;
    logic             done_q;
`endif

    assign wr_ch    = cfg_wr && (cfg_ch == 3'(c));
    assign tick_now = en_q && (cnt_q == div_q);

    // Next pattern value that a tick would apply in the current mode.
    always_comb begin
      pat_upd = pat_q;
      case (mode_q)
        MODE_HOLD:   pat_upd = pat_q;
        MODE_TOGGLE: pat_upd = ~pat_q;
        MODE_WALK:   pat_upd = (pat_q << 1) | (pat_q >> (WIDTH - 1));
        MODE_COUNT:  pat_upd = pat_q + WIDTH'(1);
        default:     pat_upd = pat_q;
      endcase
    end

    // Divider, mode update and config writes; a write to the same register
    // on a tick edge is assigned last so it overrides the tick's effect.
    always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
        pat_q   <= '0;
        div_q   <= '0;
        cnt_q   <= '0;
        mode_q  <= MODE_HOLD;
        en_q    <= 1'b0;
        tick_q  <= 1'b0;
`ifdef GPIO_WIGGLE_BURST_EN
        burst_q <= '0;
        bleft_q <= '0;
        done_q  <= 1'b0;
`endif
      end else begin
        tick_q <= tick_now;
`ifdef GPIO_WIGGLE_BURST_EN
        done_q <= 1'b0;
`endif
        if (tick_now) begin
          cnt_q <= '0;
          pat_q <= pat_upd;
`ifdef GPIO_WIGGLE_BURST_EN
          if (bleft_q != 16'd0) begin
            bleft_q <= bleft_q - 16'd1;
            if (bleft_q == 16'd1) begin
              en_q   <= 1'b0;
              done_q <= 1'b1;
            end
          end
`endif
        end else if (en_q) begin
          cnt_q <= cnt_q + DIV_W'(1);
        end else begin
          cnt_q <= '0;
        end

        if (wr_ch) begin
          case (cfg_sel)
            SEL_PATTERN: begin
              pat_q <= cfg_wdata[WIDTH-1:0];
              cnt_q <= '0;
            end
            SEL_DIV: begin
              div_q <= DIV_W'(cfg_wdata);
              cnt_q <= '0;
            end
            SEL_MODE: mode_q <= cfg_wdata[1:0];
            SEL_CTRL: begin
              en_q <= cfg_wdata[0];
              // Any change of enable restarts the divider from zero.
              if (cfg_wdata[0] != en_q) cnt_q <= '0;
`ifdef GPIO_WIGGLE_BURST_EN
              if (cfg_wdata[0] && !en_q) bleft_q <= burst_q;
`endif
            end
`ifdef GPIO_WIGGLE_BURST_EN
            SEL_BURST: burst_q <= cfg_wdata[15:0];
`endif
            default: ;
          endcase
        end
      end
    end

    assign gpio[c*WIDTH +: WIDTH] = pat_q;
    assign tick[c]                = tick_q;
`ifdef GPIO_WIGGLE_BURST_EN
    assign done[c]                = done_q;
`else
    assign done[c]                = 1'b0;
`endif
  end

endmodule

// File: doc/gpio_wiggle_gen.md
# gpio_wiggle_gen

Multi-channel GPIO pattern generator, the parametrised successor to the fixed two-bank GPIO wiggle logic on the Titan board. It drives `CHANNELS` output banks of `WIDTH` bits from the board oscillator domain. Each bank runs its own divider and one of four pattern modes: hold, toggle, walking-one rotate, or binary count. A simple register-write port configures the block and sits beside the existing PCIe and DDR3 logic in the top level.

## Interface
- `CHANNELS`, 2: number of independent output banks, 1 to 8.
- `WIDTH`, 32: bits per bank, 1 to 32.
- `DIV_W`, 24: divider counter width.
- `osc` in 1: single clock. Every flop runs on its rising edge.
- `rst` in 1: reset, asynchronous and active-high. It clears all state.
- `cfg_wr` in 1: single-cycle write strobe.
- `cfg_ch` in 3: target channel. Writes with `cfg_ch >= CHANNELS` are ignored.
- `cfg_sel` in 3: target register.
  - 0 = PATTERN
  - 1 = DIV
  - 2 = MODE
  - 3 = CTRL
  - 4 = BURST (only with the macro)
  - 5 to 7 ignored
- `cfg_wdata` in 32: write data, LSB-aligned. Fields are truncated to their register width.
- `gpio` out CHANNELS*WIDTH: bank c occupies bits [c*WIDTH +: WIDTH].
- `tick` out CHANNELS: 1-cycle pulse when a channel's divider expires while enabled.
- `done` out CHANNELS: 1-cycle pulse at burst completion. Tied 0 without the macro.

## Operation
Per-channel state:
- `pat[WIDTH]`, which is the `gpio` bank register
- `div[DIV_W]`
- `cnt[DIV_W]`
- `mode[2]`
- `en`
- `burst[16]` and `bleft[16]` (macro only)

Divider:
- While `en`=1: if `cnt == div`, assert `tick`, set `cnt` to 0 and apply the mode update. Otherwise `cnt` increments.
- Ticks therefore occur every `div+1` cycles. `div`=0 gives a tick every cycle.
- While `en`=0: `cnt` is held at 0, there is no tick and `pat` holds.

Mode updates applied on each tick:
- 0 HOLD: `pat` unchanged. `tick` still pulses.
- 1 TOGGLE: `pat <= ~pat`.
- 2 WALK: rotate left by 1 within WIDTH. The MSB wraps to bit 0. An all-zero `pat` stays zero.
- 3 COUNT: `pat <= pat + 1` modulo 2^WIDTH. All-ones wraps to 0.

Register writes take effect on the next edge:
- PATTERN: loads `pat` and clears `cnt`.
- DIV: loads `div` and clears `cnt`.
- MODE: loads `mode`. `cnt` is not cleared.
- CTRL: bit0 loads `en`. A 0→1 transition clears `cnt` and loads `bleft <= burst`.

Simultaneous events:
- A PATTERN write in the same cycle as a tick: the write wins and the mode update is discarded. `tick` still pulses.
- A DIV write in the same cycle as a tick: `tick` pulses, `pat` updates, and the new `div` applies from `cnt`=0.
- A write to channel A never affects channel B.

Reset: `rst` is asserted asynchronously mid-operation. On assertion, every register returns to its reset value immediately, with no glitch beyond the async clear. Operation resumes on the first edge after deassertion, with all channels disabled.

## Timing
- Reset values:
  - `gpio` = 0, `tick` = 0, `done` = 0
  - `pat` = 0, `div` = 0, `cnt` = 0
  - `mode` = HOLD, `en` = 0, `burst` = 0, `bleft` = 0
- `gpio` is registered. A PATTERN write at edge N shows on `gpio` after edge N.
- A tick at edge N updates `gpio` at edge N. `tick` is high during the cycle following edge N.
- Enabling at edge E with `div`=D: the first tick occurs at edge E+D+1.
- Write-to-output latency is 1 cycle. No handshake: a write is always accepted, and there is no back-pressure.

## Configuration
Macro: `GPIO_WIGGLE_BURST_EN`.

With the macro defined:
- BURST (`cfg_sel`=4) loads `burst[15:0]`.
- While `en`=1 and `bleft`≠0, each tick decrements `bleft`.
- The tick that moves `bleft` from 1 to 0 also clears `en` on the same edge and pulses `done` for 1 cycle. The pattern update for that tick is applied.
- `burst`=0 means free-running.
- Re-enabling reloads `bleft`.

Without the macro:
- No burst registers exist.
- Writes with `cfg_sel`=4 are ignored.
- `done` is constant 0.
- Channels run until CTRL is cleared.

## Test plan
- **Reset and defaults:** assert `rst` for 5 cycles, then idle 20 cycles → `gpio`=0, `tick`=0, `done`=0 throughout.
- **TOGGLE, div 4:** ch0 PATTERN=0x0000FFFF, DIV=4, MODE=1, CTRL=1 → `gpio[31:0]` alternates 0xFFFF0000 and 0x0000FFFF every 5 cycles. First change is 5 cycles after the enable edge. ch1 `gpio` stays 0.
- **WALK wrap (WIDTH=32):** ch1 PATTERN=0x80000000, MODE=2, DIV=0, CTRL=1 → `gpio[63:32]` goes 0x00000001, then 0x00000002, one step per cycle. `tick[1]` is high every cycle.
- **COUNT wrap and collision:** ch0 PATTERN=0xFFFFFFFE, MODE=3, DIV=0, enable → 0xFFFFFFFF, then 0x00000000. A PATTERN=0x5 write coincident with a tick → `gpio`=0x5 next cycle, not the count value.
- **Burst (macro on):** ch0 BURST=3, DIV=1, MODE=1, PATTERN=0, CTRL=1 → exactly 3 ticks (`gpio` 0xFFFFFFFF, 0, 0xFFFFFFFF). `done[0]` pulses once with the third tick, then the output holds 0xFFFFFFFF. With the macro off, the same stimulus runs free and `done`=0.
- **Async reset mid-run:** pulse `rst` between edges during TOGGLE → `gpio` goes to 0 immediately, and stays 0 after release until reconfigured.
